filter_obuf: RTL
================

# filter_obuf

Output buffer stage placed directly downstream of the filter datapath. It accepts filtered samples on the filter's `ext_out`/`extvalid_out` pair and returns back-pressure through `extready_in`. Samples are queued in a small first-word-fall-through FIFO and presented to the system side on a valid/ready interface. The block also keeps a sticky overflow flag and a wrapping count of accepted samples for status readout.

## Interface
- `DEPTH`, default `OBUF_DEPTH` (4): FIFO entries; power of two, at least 2.
- `CNTBITS`, default 16: width of the accepted-sample counter.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset; one clock domain only.
- `ext_in`, in, `DATABITS`: filtered sample; connects to the filter's `ext_out`.
- `extvalid_in`, in, 1: sample present; connects to the filter's `extvalid_out`.
- `extready_out`, out, 1: buffer can accept a sample; connects to the filter's `extready_in`.
- `out_data`, out, `DATABITS`: head-of-FIFO sample.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: consumer takes `out_data`.
- `clr_in`, in, 1: synchronous clear of `overflow_out` and `count_out` only.
- `level_out`, out, `$clog2(DEPTH+1)`: current fill level.
- `overflow_out`, out, 1: sticky; a sample was offered while the buffer was full.
- `count_out`, out, `CNTBITS`: number of accepted samples, modulo 2^`CNTBITS`.

## Operation
- Push: on a clock edge where `extvalid_in && extready_out`, write `ext_in` to `mem[wr_ptr]`, advance `wr_ptr`, and increment `count_out`.
- `extready_out = (level < DEPTH)`. It is decoded from the registered level only, so it never combinationally depends on `out_ready`.
- Drop: on an edge where `extvalid_in && !extready_out`, the sample is discarded and `overflow_out` is set to 1. It stays set until `clr_in` or `rst`.
- Pop: on an edge where `out_valid && out_ready`, advance `rd_ptr`.
- `out_ready` while empty has no effect.
- `out_valid = (level != 0)`.
- `out_data = mem[rd_ptr]` (first-word fall-through). Its value is don't-care while `out_valid` is 0.
- Push and pop on the same edge: level is unchanged and both pointers advance.
- At full with a simultaneous pop: the push is still refused (`extready_out` was 0) and the sample is dropped.
- Level update: level +1 on push only, −1 on pop only, otherwise unchanged. Level never exceeds `DEPTH` and never underflows.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
- `count_out` wraps from all-ones to 0 with no flag.
- `clr_in` has priority over a same-cycle set of `overflow_out` and over a same-cycle increment of `count_out`: both read 0 after that edge. FIFO contents and pointers are unaffected by `clr_in`.
- Reset, asserted at any time, including mid-transfer: pointers, level, `count_out` and `overflow_out` all go to 0 immediately.
  - Reset values: `out_valid` = 0, `extready_out` = 1, `level_out` = 0.
  - FIFO memory is not reset.

## Timing
- Latency: a sample pushed at edge k appears on `out_data` with `out_valid` = 1 after edge k, provided the FIFO was empty. Otherwise it appears after all older entries have popped.
- `extready_out` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- Sustained throughput is one sample per clock whenever `out_ready` is held at 1.
- All outputs are registered or decoded from registers. There are no combinational in-to-out paths.

## Structure
- `myfilter_pkg` gains the constant `OBUF_DEPTH` = 4. `DATABITS` already lives in that package.
- Single module; no sub-module is needed.
- Storage is a register array with no reset.

## Test plan
- Reset, then push 0x0011, 0x0022 and 0x0033 back-to-back with `out_ready` = 0 → `level_out` = 3, `extready_out` = 1, `out_data` = 0x0011. Then raise `out_ready` → 0x0011, 0x0022, 0x0033 on consecutive cycles, followed by `out_valid` = 0 and `count_out` = 3.
- Fill with 4 samples, then offer a fifth (0x00FF) with `out_ready` = 0 → `extready_out` = 0, the sample is dropped, `overflow_out` = 1, `level_out` = 4. Pulse `clr_in` → `overflow_out` = 0 and `count_out` = 0.
- From full, assert `out_ready` and `extvalid_in` together for one cycle → the push is refused and `level_out` = 3. The next cycle's push is accepted.
- Hold `extvalid_in` and `out_ready` at 1 for 20 cycles with an incrementing sample value → output sequence matches the input, `level_out` stays at 1, and both pointers wrap correctly.
- Preload `count_out` to 0xFFFF (after 65535 pushes, or by force in the bench) and push once → `count_out` = 0x0000.
- Assert `rst` mid-stream with 2 entries queued → immediately `out_valid` = 0, `level_out` = 0 and `extready_out` = 1. After reset releases, the first new push is the first sample output.

Source files
------------

// File: rtl/myfilter_pkg.sv
// Shared constants for the filter datapath and its output buffer.
package myfilter_pkg;

    localparam int unsigned DATABITS   = 16;
    localparam int unsigned OBUF_DEPTH = 4;

endpackage : myfilter_pkg

// File: rtl/filter_obuf.sv
// Output buffer behind the filter: FWFT FIFO with valid/ready output,
// sticky overflow flag and wrapping accepted-sample counter.
module filter_obuf
    import myfilter_pkg::*;
#(
    parameter int unsigned DEPTH   = OBUF_DEPTH,
    parameter int unsigned CNTBITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATABITS-1:0]        ext_in,
    input  logic                       extvalid_in,
    output logic                       extready_out,
    output logic [DATABITS-1:0]        out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       clr_in,
    output logic [$clog2(DEPTH+1)-1:0] level_out,
    output logic                       overflow_out,
    output logic [CNTBITS-1:0]         count_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [DATABITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q,  level_d;
    logic [CNTBITS-1:0]  count_q,  count_d;
    logic                ovf_q,    ovf_d;
    logic                push, pop, drop;

    // Handshake outputs decode only registered state, so out_ready never
    // reaches extready_out combinationally.
    assign extready_out = (level_q < LW'(DEPTH));
    assign out_valid    = (level_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign level_out    = level_q;
    assign overflow_out = ovf_q;
    assign count_out    = count_q;

    assign push = extvalid_in && extready_out;
    assign drop = extvalid_in && !extready_out;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (clr_in) begin
            ovf_d   = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ext_in;
        end
    end

endmodule : filter_obuf
